prbs_channel_tx: RTL and testbench

//  Transmit-side stimulus source for the DSP equalizer path: generates a PRBS9 BPSK symbol

---
 rtl/prbs_channel_tx.sv | 150 +++++++++++++++
 tb/tb_prbs_channel_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_channel_tx.sv
`default_nettype none
// ============================================================================
// Module      : prbs_channel_tx
// Description : Transmit-side stimulus source for the DSP equalizer path.
//               A PRBS9 (x^9+x^5+1) bit stream is mapped to BPSK symbols
//               (0 -> +1, 1 -> -1) and passed through a 3-tap FIR channel
//               model with four selectable presets. The saturated S(11,7)
//               result drives the equalizer input.
//               Optional build macro CH_NOISE_EN adds a 16-bit LFSR noise
//               term (scaled by i_noise_shift) before saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_channel_tx #(
  parameter int         DATA_BW = 11,
  parameter int         COEF_BW = 9,
  parameter int         N_TAPS  = 3,
  parameter logic [8:0] SEED    = 9'h1FF
) (
  input  logic                      clockdsp,
  input  logic                      soft_reset,
  input  logic                      i_en,
  input  logic [1:0]                i_ch_sel,
  input  logic [2:0]                i_noise_shift,
  output logic                      o_symbol,
  output logic signed [DATA_BW-1:0] o_data
);

  // Two guard bits cover the worst-case tap sum plus noise without wrapping.
  localparam int                       ACC_BW    = DATA_BW + 2;
  localparam int                       SAT_MAX_I = (1 << (DATA_BW - 1)) - 1;
  localparam logic signed [ACC_BW-1:0] SAT_MAX   = ACC_BW'(SAT_MAX_I);
  localparam logic signed [ACC_BW-1:0] SAT_MIN   = ACC_BW'(-SAT_MAX_I - 1);

  // Symbol encodings held in the delay line (0 only after reset).
  localparam logic signed [1:0] SYM_POS = 2'sb01;
  localparam logic signed [1:0] SYM_NEG = 2'sb11;

  // Channel tap presets in S(9,7); taps beyond index 2 are zero.
  function automatic logic signed [COEF_BW-1:0] tap_coef(input logic [1:0] sel, input int k);
    logic signed [COEF_BW-1:0] c;
    c = '0;
    case (sel)
      2'd0: begin
        if (k == 0) c = COEF_BW'(128);
      end
      2'd1: begin
        if (k == 0) c = COEF_BW'(128);
        if (k == 1) c = COEF_BW'(32);
      end
      2'd2: begin
        if (k == 0) c = COEF_BW'(16);
        if (k == 1) c = COEF_BW'(128);
        if (k == 2) c = COEF_BW'(-32);
      end
      default: begin
        if (k == 0) c = COEF_BW'(64);
        if (k == 1) c = COEF_BW'(64);
        if (k == 2) c = COEF_BW'(32);
      end
    endcase
    return c;
  endfunction

  logic [8:0]               lfsr;
  logic signed [1:0]        dly [N_TAPS];
  logic [1:0]               ch_sel_q;
  logic signed [ACC_BW-1:0] prod [N_TAPS];
  logic signed [ACC_BW-1:0] noise_val;
  logic signed [ACC_BW-1:0] fir_sum;
  logic signed [DATA_BW-1:0] sat_val;

  // Per-tap product: symbols are +/-1 or 0, so each product is a signed
  // select of the coefficient rather than a multiply.
  for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
    logic signed [COEF_BW-1:0] coef;
    logic signed [ACC_BW-1:0]  coef_ext;
    assign coef     = tap_coef(ch_sel_q, k);
    assign coef_ext = {{(ACC_BW - COEF_BW){coef[COEF_BW-1]}}, coef};

    // Select +h, -h or 0 according to the stored symbol.
    always_comb begin
      prod[k] = '0;
      if (dly[k] == SYM_POS)      prod[k] = coef_ext;
      else if (dly[k] == SYM_NEG) prod[k] = -coef_ext;
    end
  end

`ifdef CH_NOISE_EN
  logic [15:0]       nlfsr;
  logic signed [7:0] noise8;

  assign noise8    = $signed(nlfsr[7:0]) >>> i_noise_shift;
  assign noise_val = {{(ACC_BW - 8){noise8[7]}}, noise8};

  // Noise LFSR x^16+x^14+x^13+x^11+1, stepped in lockstep with the symbol stream.
  always_ff @(posedge clockdsp) begin
    if (soft_reset) begin
      nlfsr <= 16'hACE1;
    end else if (i_en) begin
      nlfsr <= {nlfsr[14:0], nlfsr[15] ^ nlfsr[13] ^ nlfsr[12] ^ nlfsr[10]};
    end
  end
`else
  logic unused_noise_shift;
  assign unused_noise_shift = ^i_noise_shift;
  assign noise_val          = '0;
`endif

  // Accumulate the tap products and noise at full accumulator width.
  always_comb begin
    fir_sum = noise_val;
    for (int k = 0; k < N_TAPS; k++) begin
      fir_sum = fir_sum + prod[k];
    end
  end

  // Clamp the accumulator into the output sample range.
  always_comb begin
    sat_val = fir_sum[DATA_BW-1:0];
    if (fir_sum > SAT_MAX)      sat_val = SAT_MAX[DATA_BW-1:0];
    else if (fir_sum < SAT_MIN) sat_val = SAT_MIN[DATA_BW-1:0];
  end

  // PRBS generator, symbol delay line and output registers; the FIR result
  // registered here comes from the delay line before this edge's shift.
  always_ff @(posedge clockdsp) begin
    if (soft_reset) begin
      lfsr     <= SEED;
      ch_sel_q <= '0;
      o_symbol <= 1'b0;
      o_data   <= '0;
      for (int k = 0; k < N_TAPS; k++) begin
        dly[k] <= '0;
      end
    end else begin
      ch_sel_q <= i_ch_sel;
      if (i_en) begin
        lfsr     <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        dly[0]   <= lfsr[8] ? SYM_NEG : SYM_POS;
        for (int k = 1; k < N_TAPS; k++) begin
          dly[k] <= dly[k-1];
        end
        o_symbol <= lfsr[8];
        o_data   <= sat_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prbs_channel_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs_channel_tx
// Description : Self-checking bench for prbs_channel_tx. The reference model
//               builds the PRBS9 sequence from its bit recurrence and
//               computes each output as a plain tap-weighted sum of symbols.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs_channel_tx;

  logic              clk = 1'b0;
  logic              soft_reset;
  logic              i_en;
  logic [1:0]        i_ch_sel;
  logic [2:0]        i_noise_shift;
  logic              o_symbol;
  logic signed [10:0] o_data;

  always #5 clk = ~clk;

  prbs_channel_tx dut (
    .clockdsp      (clk),
    .soft_reset    (soft_reset),
    .i_en          (i_en),
    .i_ch_sel      (i_ch_sel),
    .i_noise_shift (i_noise_shift),
    .o_symbol      (o_symbol),
    .o_data        (o_data)
  );

`ifdef CH_NOISE_EN
  localparam int TOL = 1;
`else
  localparam int TOL = 0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit prbs [511];
  int H [4][3] = '{'{128, 0, 0}, '{128, 32, 0}, '{16, 128, -32}, '{64, 64, 32}};
  int idx;        // enabled edges since reset
  int sel_q_m;    // channel select seen by the next enabled edge
  int exp_data;
  bit exp_sym;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sym_at(input int m);
    if (m < 0) return 0;
    return prbs[m % 511] ? -1 : 1;
  endfunction

  // Output after the n-th enabled edge: channel applied to symbols up to n-2.
  function automatic int model_data(input int n, input int sel);
    int acc;
    acc = 0;
    if (n == 0) return 0;
    for (int j = 0; j < 3; j++) acc += H[sel][j] * sym_at(n - 2 - j);
    if (acc > 1023)  acc = 1023;
    if (acc < -1024) acc = -1024;
    return acc;
  endfunction

  task automatic step(input bit en, input bit rst);
    i_en       = en;
    soft_reset = rst;
    @(posedge clk);
    if (rst) begin
      idx      = 0;
      exp_data = 0;
      exp_sym  = 1'b0;
      sel_q_m  = 0;
    end else begin
      if (en) begin
        idx++;
        exp_sym  = prbs[(idx - 1) % 511];
        exp_data = model_data(idx, sel_q_m);
      end
      sel_q_m = int'(i_ch_sel);
    end
    #1;
    soft_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_ch_sel = 2'd0;
    step(1'b1, 1'b1);
    n_checks++;
    if (o_data !== 11'sd0) $display("FAIL reset_data: got %0d expected 0", o_data);
    else n_pass++;
    n_checks++;
    if (o_symbol !== 1'b0) $display("FAIL reset_symbol: got %0b expected 0", o_symbol);
    else n_pass++;
  endtask

  // Ten enabled edges straight after reset with an all-ones seed.
  task automatic check_replay(input string tag);
    for (int e = 1; e <= 10; e++) begin
      int want;
      step(1'b1, 1'b0);
      want = (e == 1) ? 0 : -128;
      n_checks++;
      if (iabs(int'(o_data) - want) > TOL)
        $display("FAIL %s_data edge %0d: got %0d expected %0d", tag, e, o_data, want);
      else n_pass++;
      if (e <= 9) begin
        n_checks++;
        if (o_symbol !== 1'b1) $display("FAIL %s_symbol edge %0d: got %0b expected 1", tag, e, o_symbol);
        else n_pass++;
      end
    end
  endtask

  task automatic test_prbs();
    bit seq [1022];
    int ones;
    int bad_period;
    i_ch_sel = 2'd0;
    step(1'b0, 1'b1);
    check_replay("startup");
    step(1'b0, 1'b1);
    for (int i = 0; i < 1022; i++) begin
      step(1'b1, 1'b0);
      seq[i] = o_symbol;
      n_checks++;
      if (o_symbol !== exp_sym || iabs(int'(o_data) - exp_data) > TOL)
        $display("FAIL prbs edge %0d: got sym %0b data %0d expected sym %0b data %0d",
                 idx, o_symbol, o_data, exp_sym, exp_data);
      else n_pass++;
    end
    ones = 0;
    bad_period = 0;
    for (int i = 0; i < 511; i++) begin
      ones += int'(seq[i]);
      if (seq[i] !== seq[i + 511]) bad_period++;
    end
    n_checks++;
    if (ones != 256) $display("FAIL prbs_ones: got %0d expected 256", ones);
    else n_pass++;
    n_checks++;
    if (bad_period != 0) $display("FAIL prbs_period: got %0d differing bits expected 0", bad_period);
    else n_pass++;
  endtask

  task automatic test_heavy_isi();
    int bad_set;
    i_ch_sel = 2'd3;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    bad_set = 0;
    for (int i = 0; i < 2000; i++) begin
      int v;
      step(1'b1, 1'b0);
      v = int'(o_data);
      n_checks++;
      if (iabs(v - exp_data) > TOL)
        $display("FAIL isi edge %0d: got %0d expected %0d", idx, v, exp_data);
      else n_pass++;
      if (idx >= 4 && TOL == 0 && !(iabs(v) == 160 || iabs(v) == 96 || iabs(v) == 32)) bad_set++;
    end
    n_checks++;
    if (bad_set != 0) $display("FAIL isi_value_set: got %0d out-of-set values expected 0", bad_set);
    else n_pass++;
  endtask

  task automatic test_presets();
    for (int s = 0; s < 4; s++) begin
      i_ch_sel = 2'(s);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      for (int i = 0; i < 200 + int'($urandom_range(0, 100)); i++) begin
        step(1'b1, 1'b0);
        n_checks++;
        if (iabs(int'(o_data) - exp_data) > TOL || o_symbol !== exp_sym)
          $display("FAIL preset%0d edge %0d: got data %0d sym %0b expected data %0d sym %0b",
                   s, idx, o_data, o_symbol, exp_data, exp_sym);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sel_change();
    i_ch_sel = 2'd0;
    step(1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) i_ch_sel = 2'($urandom_range(0, 3));
      step(1'b1, 1'b0);
      n_checks++;
      if (iabs(int'(o_data) - exp_data) > TOL)
        $display("FAIL sel_change edge %0d: got %0d expected %0d", idx, o_data, exp_data);
      else n_pass++;
    end
  endtask

  task automatic test_enable_toggle();
    i_ch_sel = 2'($urandom_range(0, 3));
    step(1'b0, 1'b1);
    for (int i = 0; i < 500; i++) begin
      bit en;
      en = (i < 200) ? bit'(i % 2 == 0) : bit'($urandom_range(0, 1));
      if (i >= 300 && $urandom_range(0, 15) == 0) i_ch_sel = 2'($urandom_range(0, 3));
      step(en, 1'b0);
      n_checks++;
      if (iabs(int'(o_data) - exp_data) > TOL || o_symbol !== exp_sym)
        $display("FAIL enable_toggle cycle %0d en %0b: got data %0d sym %0b expected data %0d sym %0b",
                 i, en, o_data, o_symbol, exp_data, exp_sym);
      else n_pass++;
    end
  endtask

  task automatic test_midstream_reset();
    i_ch_sel = 2'd0;
    step(1'b0, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    n_checks++;
    if (o_data !== 11'sd0 || o_symbol !== 1'b0)
      $display("FAIL midreset_clear: got data %0d sym %0b expected data 0 sym 0", o_data, o_symbol);
    else n_pass++;
    check_replay("midreset");
  endtask

`ifdef CH_NOISE_EN
  task automatic test_noise();
    int diff_a [64];
    i_noise_shift = 3'd0;
    i_ch_sel      = 2'd0;
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b0, 1'b1);
      for (int i = 0; i < 64; i++) begin
        int d;
        step(1'b1, 1'b0);
        d = int'(o_data) - exp_data;
        n_checks++;
        if (iabs(d) > 128) $display("FAIL noise_bound edge %0d: got diff %0d expected within 128", idx, d);
        else n_pass++;
        if (pass == 0) diff_a[i] = d;
        else begin
          n_checks++;
          if (d != diff_a[i]) $display("FAIL noise_restart edge %0d: got diff %0d expected %0d", idx, d, diff_a[i]);
          else n_pass++;
        end
      end
    end
    i_noise_shift = 3'd7;
  endtask
`endif

  initial begin
    prbs = '{default: 1'b0};
    for (int i = 0; i < 9; i++) prbs[i] = 1'b1;
    for (int i = 0; i + 9 < 511; i++) prbs[i + 9] = prbs[i] ^ prbs[i + 4];

    soft_reset    = 1'b1;
    i_en          = 1'b0;
    i_ch_sel      = 2'd0;
    i_noise_shift = 3'd7;
    idx           = 0;
    sel_q_m       = 0;
    exp_data      = 0;
    exp_sym       = 1'b0;

    test_reset();
    test_prbs();
    test_heavy_isi();
    test_presets();
    test_sel_change();
    test_enable_toggle();
    test_midstream_reset();
`ifdef CH_NOISE_EN
    test_noise();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
